// File: rtl/peripheral_defines.sv
// Shared VGA console constants, state encoding and glyph-cell address helper.
package peripheral_defines;

  localparam int unsigned VGA_BLOCK_HNUM = 80;
  localparam int unsigned VGA_BLOCK_VNUM = 30;
  localparam logic [31:0] VGA_OFFSET_REG = 32'h0000_1000;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StClrLine,
    StSetOfs,
    StClrAll
  } Console_state_t;

  typedef logic [11:0] Graphics_block_addr_t;

  // top+row < 2*vnum, so one conditional subtract is a full modulo
  function automatic Graphics_block_addr_t cell_addr(input logic [4:0] top,
                                                     input logic [4:0] row,
                                                     input logic [6:0] col,
                                                     input int unsigned hnum,
                                                     input int unsigned vnum);
    logic [5:0] r;
    r = {1'b0, top} + {1'b0, row};
    if (r >= 6'(vnum)) r = r - 6'(vnum);
    return Graphics_block_addr_t'(r) * Graphics_block_addr_t'(hnum)
           + Graphics_block_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_console_ctrl_if.sv
// Character handshake plus VGA write bus of the console controller.
interface vga_console_ctrl_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        write_op;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;

  // master is the console controller; slave is the character source plus VGA peripheral
  modport master (
    input  char_valid, char_data,
    output char_ready, write_op, bus_addr, bus_data
  );
  modport slave (
    output char_valid, char_data,
    input  char_ready, write_op, bus_addr, bus_data
  );
endinterface

// File: rtl/vga_bus_beat.sv
// Holds one VGA bus write stable for WRITE_BEATS cycles; done marks the last cycle.
module vga_bus_beat #(
  parameter int unsigned WRITE_BEATS = 2
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        write_op,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        done
);
  localparam logic [7:0] CntLast = 8'(WRITE_BEATS - 1);

  logic        active_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, data_q;

  // start on the done cycle chains the next beat with no gap in write_op
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= addr;
      data_q   <= data;
    end else if (active_q) begin
      if (cnt_q == CntLast) active_q <= 1'b0;
      else                  cnt_q    <= cnt_q + 8'd1;
    end
  end

  assign done     = active_q & (cnt_q == CntLast);
  assign write_op = active_q;
  assign bus_addr = addr_q;
  assign bus_data = data_q;
endmodule

// File: rtl/vga_console_ctrl.sv
// Character-stream console: cursor tracking, glyph writes, scrolling and full clear.
module vga_console_ctrl
  import peripheral_defines::*;
#(
  parameter int unsigned HNUM        = VGA_BLOCK_HNUM,
  parameter int unsigned VNUM        = VGA_BLOCK_VNUM,
  parameter logic [31:0] OFS_ADDR    = VGA_OFFSET_REG,
  parameter int unsigned WRITE_BEATS = 2
) (
  input  logic                      clk_50M,
  input  logic                      rst_n,
  input  logic                      clear_req,
  output logic                      busy,
  output logic [6:0]                cursor_col,
  output logic [4:0]                cursor_row,
  vga_console_ctrl_if.master        con
);
  localparam logic [6:0]  ColLast     = 7'(HNUM - 1);
  localparam logic [4:0]  RowLast     = 5'(VNUM - 1);
  localparam logic [11:0] CntLineLast = 12'(HNUM - 1);
  localparam logic [11:0] CntAllLast  = 12'(HNUM * VNUM - 1);
  localparam logic [31:0] SpaceWord   = {24'd0, ASCII_SPACE};

  Console_state_t state_q, state_d;
  logic [6:0]  col_q, col_d, wcol_q, wcol_d;
  logic [4:0]  row_q, row_d, top_q, top_d, ofs_q, ofs_d;
  logic [11:0] cnt_q, cnt_d;
  logic        is_bs_q, is_bs_d, full_q, full_d, clr_pending_q, clr_pending_d;
  logic        ready_en_q;

  logic        beat_start, beat_done;
  logic [31:0] beat_addr, beat_data;

  Graphics_block_addr_t cur_addr, bs_addr, line_base;
  logic [4:0] top_inc;
  logic       accept, printable;

  assign cur_addr  = cell_addr(top_q, row_q, col_q, HNUM, VNUM);
  assign bs_addr   = cell_addr(top_q, row_q, col_q - 7'd1, HNUM, VNUM);
  assign line_base = cell_addr(top_q, 5'd0, 7'd0, HNUM, VNUM);
  assign top_inc   = (top_q == RowLast) ? 5'd0 : top_q + 5'd1;
  assign printable = (con.char_data >= 8'h20) && (con.char_data <= 8'h7E);

  // ready_en_q keeps char_ready low while reset is held; clear_req wins over a same-cycle byte
  assign con.char_ready = (state_q == StIdle) & ~clr_pending_q & ~clear_req & ready_en_q;
  assign accept         = con.char_valid & con.char_ready;
  assign busy           = (state_q != StIdle) | clr_pending_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    top_d         = top_q;
    wcol_d        = wcol_q;
    is_bs_d       = is_bs_q;
    ofs_d         = ofs_q;
    full_d        = full_q;
    cnt_d         = cnt_q;
    clr_pending_d = clr_pending_q | clear_req;
    beat_start    = 1'b0;
    beat_addr     = '0;
    beat_data     = '0;
    case (state_q)
      StIdle: begin
        if (clr_pending_q | clear_req) begin
          beat_start = 1'b1;
          beat_data  = SpaceWord;
          cnt_d      = '0;
          state_d    = StClrAll;
        end else if (accept) begin
          if (printable) begin
            beat_start = 1'b1;
            beat_addr  = {20'd0, cur_addr};
            beat_data  = {24'd0, con.char_data};
            wcol_d     = col_q;
            is_bs_d    = 1'b0;
            state_d    = StPut;
          end else if (con.char_data == ASCII_LF) begin
            if (row_q != RowLast) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              beat_start = 1'b1;
              beat_addr  = {20'd0, line_base};
              beat_data  = SpaceWord;
              cnt_d      = '0;
              state_d    = StClrLine;
            end
          end else if (con.char_data == ASCII_CR) begin
            col_d = '0;
          end else if (con.char_data == ASCII_BS && col_q != 7'd0) begin
            beat_start = 1'b1;
            beat_addr  = {20'd0, bs_addr};
            beat_data  = SpaceWord;
            wcol_d     = col_q - 7'd1;
            is_bs_d    = 1'b1;
            state_d    = StPut;
          end
        end
      end
      StPut: begin
        if (beat_done) begin
          state_d = StIdle;
          if (is_bs_q) begin
            col_d = wcol_q;
          end else if (wcol_q != ColLast) begin
            col_d = wcol_q + 7'd1;
          end else if (row_q != RowLast) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            // implicit newline on the last row: scroll, cursor moves when SET_OFS ends
            beat_start = 1'b1;
            beat_addr  = {20'd0, line_base};
            beat_data  = SpaceWord;
            cnt_d      = '0;
            state_d    = StClrLine;
          end
        end
      end
      StClrLine: begin
        if (beat_done) begin
          beat_start = 1'b1;
          if (cnt_q == CntLineLast) begin
            beat_addr = OFS_ADDR;
            beat_data = {27'd0, top_inc};
            ofs_d     = top_inc;
            full_d    = 1'b0;
            state_d   = StSetOfs;
          end else begin
            cnt_d     = cnt_q + 12'd1;
            beat_addr = {20'd0, line_base + cnt_q + 12'd1};
            beat_data = SpaceWord;
          end
        end
      end
      StClrAll: begin
        if (beat_done) begin
          beat_start = 1'b1;
          if (cnt_q == CntAllLast) begin
            beat_addr = OFS_ADDR;
            beat_data = '0;
            ofs_d     = '0;
            full_d    = 1'b1;
            state_d   = StSetOfs;
          end else begin
            cnt_d     = cnt_q + 12'd1;
            beat_addr = {20'd0, cnt_q + 12'd1};
            beat_data = SpaceWord;
          end
        end
      end
      StSetOfs: begin
        if (beat_done) begin
          top_d   = ofs_q;
          col_d   = '0;
          state_d = StIdle;
          if (full_q) begin
            row_d         = '0;
            clr_pending_d = clear_req;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      col_q         <= '0;
      row_q         <= '0;
      top_q         <= '0;
      wcol_q        <= '0;
      is_bs_q       <= 1'b0;
      ofs_q         <= '0;
      full_q        <= 1'b0;
      cnt_q         <= '0;
      clr_pending_q <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      top_q         <= top_d;
      wcol_q        <= wcol_d;
      is_bs_q       <= is_bs_d;
      ofs_q         <= ofs_d;
      full_q        <= full_d;
      cnt_q         <= cnt_d;
      clr_pending_q <= clr_pending_d;
      ready_en_q    <= 1'b1;
    end
  end

  vga_bus_beat #(
    .WRITE_BEATS (WRITE_BEATS)
  ) u_beat (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .start    (beat_start),
    .addr     (beat_addr),
    .data     (beat_data),
    .write_op (con.write_op),
    .bus_addr (con.bus_addr),
    .bus_data (con.bus_data),
    .done     (beat_done)
  );
endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed self-checking bench for vga_console_ctrl; write cycles are logged at negedge.
module tb_vga_console_ctrl;
  import peripheral_defines::*;

  localparam logic [31:0] OFS = VGA_OFFSET_REG;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int errors = 0;
  int checks = 0;

  logic [63:0] wq[$];

  vga_console_ctrl_if ifc ();

  vga_console_ctrl dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .con        (ifc)
  );

  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M) if (ifc.write_op) wq.push_back({ifc.bus_addr, ifc.bus_data});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk_50M);
    while (!ifc.char_ready && n < 10000) begin
      n++;
      @(negedge clk_50M);
    end
    if (n >= 10000) begin
      checks++; errors++;
      $display("FAIL push_timeout: char_ready stayed 0, byte %h", b);
    end
    ifc.char_valid = 1'b1;
    ifc.char_data  = b;
    @(posedge clk_50M);
    #1 ifc.char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk_50M);
    while (busy && n < 20000) begin
      n++;
      @(negedge clk_50M);
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int n);
    push_byte(b);
    wait_idle(n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.char_valid = 1'b0;
    ifc.char_data  = 8'h00;
    repeat (3) @(negedge clk_50M);
    checks++; if (ifc.write_op !== 1'b0) begin errors++; $display("FAIL rst_write_op: got %b want 0", ifc.write_op); end
    checks++; if (ifc.bus_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", ifc.bus_addr); end
    checks++; if (ifc.bus_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", ifc.bus_data); end
    checks++; if (ifc.char_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ifc.char_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL rst_cursor: got %0d,%0d want 0,0", cursor_col, cursor_row);
    end
    rst_n = 1'b1;
    @(negedge clk_50M);
    checks++; if (ifc.char_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", ifc.char_ready); end
  endtask

  task automatic test_put_char();
    logic [2:0] wr, rd;
    int n;
    wq.delete();
    push_byte(8'h41);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_50M);
      wr[k] = ifc.write_op;
      rd[k] = ifc.char_ready;
    end
    wait_idle(n);
    checks++; if (wr !== 3'b011) begin errors++; $display("FAIL put_write_op_shape: got %b want 011", wr); end
    checks++; if (rd !== 3'b100) begin errors++; $display("FAIL put_ready_shape: got %b want 100", rd); end
    checks++; if (wq.size() != 2 || wq[0] !== {32'd0, 32'h41} || wq[1] !== {32'd0, 32'h41}) begin
      errors++; $display("FAIL put_writes: got %0d cycles first %h want 2 cycles of 0/41", wq.size(), wq[0]);
    end
    checks++; if (cursor_col !== 7'd1) begin errors++; $display("FAIL put_cursor: got %0d want 1", cursor_col); end
  endtask

  task automatic test_line_wrap();
    int n, ofs_hits;
    send_byte(ASCII_CR, n);
    wq.delete();
    repeat (80) send_byte(8'h78, n);
    ofs_hits = 0;
    foreach (wq[i]) if (wq[i][63:32] == OFS) ofs_hits++;
    checks++; if (wq.size() != 160) begin errors++; $display("FAIL wrap_count: got %0d want 160", wq.size()); end
    checks++; if (wq[$] !== {32'd79, 32'h78}) begin errors++; $display("FAIL wrap_last: got %h want 79/78", wq[$]); end
    checks++; if (ofs_hits != 0) begin errors++; $display("FAIL wrap_no_ofs: got %0d want 0", ofs_hits); end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
      errors++; $display("FAIL wrap_cursor: got %0d,%0d want 0,1", cursor_col, cursor_row);
    end
  endtask

  task automatic test_scroll();
    int n, bad;
    wq.delete();
    repeat (28) send_byte(ASCII_LF, n);
    checks++; if (wq.size() != 0 || cursor_row !== 5'd29) begin
      errors++; $display("FAIL lf_plain: got %0d writes row %0d want 0 writes row 29", wq.size(), cursor_row);
    end
    send_byte(ASCII_LF, n);
    checks++; if (n != 162) begin errors++; $display("FAIL scroll_busy: got %0d want 162", n); end
    bad = 0;
    if (wq.size() == 162) begin
      for (int i = 0; i < 160; i++) if (wq[i] !== {32'(i / 2), 32'h20}) bad++;
      if (wq[160] !== {OFS, 32'd1} || wq[161] !== {OFS, 32'd1}) bad++;
    end else bad = -1;
    checks++; if (bad != 0) begin errors++; $display("FAIL scroll_writes: got %0d bad (size %0d) want 0", bad, wq.size()); end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin
      errors++; $display("FAIL scroll_cursor: got %0d,%0d want 0,29", cursor_col, cursor_row);
    end
    wq.delete();
    send_byte(8'h42, n);
    checks++; if (wq.size() != 2 || wq[0] !== {32'd0, 32'h42}) begin
      errors++; $display("FAIL scroll_next_char: got %0d cycles %h want 2 of 0/42", wq.size(), wq[0]);
    end
  endtask

  task automatic test_backspace();
    int n;
    logic [7:0] s [5];
    s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    send_byte(ASCII_CR, n);
    wq.delete();
    send_byte(ASCII_BS, n);
    checks++; if (wq.size() != 0 || cursor_col !== 7'd0) begin
      errors++; $display("FAIL bs_col0: got %0d writes col %0d want 0 writes col 0", wq.size(), cursor_col);
    end
    foreach (s[i]) send_byte(s[i], n);
    wq.delete();
    send_byte(ASCII_BS, n);
    checks++; if (wq.size() != 2 || wq[0] !== {32'd4, 32'h20}) begin
      errors++; $display("FAIL bs_write: got %0d cycles %h want 2 of 4/20", wq.size(), wq[0]);
    end
    checks++; if (cursor_col !== 7'd4) begin errors++; $display("FAIL bs_cursor: got %0d want 4", cursor_col); end
  endtask

  task automatic test_clear_priority();
    int n, bad;
    wq.delete();
    @(negedge clk_50M);
    clear_req = 1'b1;
    ifc.char_valid = 1'b1;
    ifc.char_data  = 8'h43;
    @(posedge clk_50M);
    #1 clear_req = 1'b0;
    n = 0;
    @(negedge clk_50M);
    while (!ifc.char_ready && n < 6000) begin
      n++;
      @(negedge clk_50M);
    end
    @(posedge clk_50M);
    #1 ifc.char_valid = 1'b0;
    checks++; if (n != 4802) begin errors++; $display("FAIL clear_blocked_cycles: got %0d want 4802", n); end
    wait_idle(n);
    bad = 0;
    if (wq.size() == 4804) begin
      for (int i = 0; i < 4800; i++) if (wq[i] !== {32'(i / 2), 32'h20}) bad++;
      if (wq[4800] !== {OFS, 32'd0} || wq[4801] !== {OFS, 32'd0}) bad++;
      if (wq[4802] !== {32'd0, 32'h43} || wq[4803] !== {32'd0, 32'h43}) bad++;
    end else bad = -1;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_writes: got %0d bad (size %0d) want 0", bad, wq.size()); end
    checks++; if (cursor_col !== 7'd1 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL clear_cursor: got %0d,%0d want 1,0", cursor_col, cursor_row);
    end
  endtask

  task automatic test_double_clear();
    int n, ofs_hits;
    send_byte(ASCII_CR, n);
    repeat (29) send_byte(ASCII_LF, n);
    wq.delete();
    push_byte(ASCII_LF);
    repeat (20) @(negedge clk_50M);
    clear_req = 1'b1;
    @(negedge clk_50M);
    clear_req = 1'b0;
    repeat (30) @(negedge clk_50M);
    clear_req = 1'b1;
    @(negedge clk_50M);
    clear_req = 1'b0;
    wait_idle(n);
    ofs_hits = 0;
    foreach (wq[i]) if (wq[i][63:32] == OFS) ofs_hits++;
    checks++; if (wq.size() != 4964) begin errors++; $display("FAIL dbl_clear_count: got %0d want 4964", wq.size()); end
    checks++; if (ofs_hits != 4) begin errors++; $display("FAIL dbl_clear_ofs: got %0d want 4", ofs_hits); end
    checks++; if (wq[$] !== {OFS, 32'd0}) begin errors++; $display("FAIL dbl_clear_last: got %h want ofs/0", wq[$]); end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL dbl_clear_cursor: got %0d,%0d want 0,0", cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    repeat (29) send_byte(ASCII_LF, n);
    push_byte(ASCII_LF);
    repeat (20) @(negedge clk_50M);
    checks++; if (ifc.write_op !== 1'b1) begin errors++; $display("FAIL mid_scroll_active: got %b want 1", ifc.write_op); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.write_op !== 1'b0 || ifc.bus_addr !== 32'd0 || ifc.bus_data !== 32'd0) begin
      errors++; $display("FAIL mid_rst_bus: got %b %h %h want 0 0 0", ifc.write_op, ifc.bus_addr, ifc.bus_data);
    end
    checks++; if (busy !== 1'b0 || ifc.char_ready !== 1'b0 || cursor_row !== 5'd0) begin
      errors++; $display("FAIL mid_rst_ctrl: busy %b ready %b row %0d want 0 0 0", busy, ifc.char_ready, cursor_row);
    end
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    checks++; if (ifc.char_ready !== 1'b1 || ifc.write_op !== 1'b0) begin
      errors++; $display("FAIL mid_rst_release: ready %b write_op %b want 1 0", ifc.char_ready, ifc.write_op);
    end
  endtask

  initial begin
    test_reset();
    test_put_char();
    test_line_wrap();
    test_scroll();
    test_backspace();
    test_clear_priority();
    test_double_clear();
    test_reset_mid_scroll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
